// File: rtl/ram_pkg.sv
// ram_pkg: shared widths and the controller state encoding for ram_burst_master.
//   DATA_W  default memory word width
//   DEPTH   default number of words in the attached RAM
//   ADDR_W  width of the burst start address / length fields
//   BEAT_W  width of the remaining-beats counter (holds 1..8)
package ram_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int BEAT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RD_ADDR = 2'd2,
        RD_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/ram_addr_gen.sv
// ram_addr_gen: burst address and beat counter.
//   clk, reset           clock, async active-high reset
//   load                 load start address and length (beats = load_len + 1)
//   step                 advance one beat: address +1 mod DEPTH, beats -1
//   load_addr, load_len  start word address, beats minus one
//   cur_addr             address of the current beat
//   next_addr            address of the following beat (wrapped)
//   last                 current beat is the final one of the burst
module ram_addr_gen #(
    parameter int DEPTH = ram_pkg::DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic                      step,
    input  logic [ram_pkg::ADDR_W-1:0] load_addr,
    input  logic [ram_pkg::ADDR_W-1:0] load_len,
    output logic [ram_pkg::ADDR_W-1:0] cur_addr,
    output logic [ram_pkg::ADDR_W-1:0] next_addr,
    output logic                      last
);
    import ram_pkg::*;

    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [BEAT_W-1:0] beats_q, beats_d;

    // Explicit wrap so a DEPTH that is not a power of two still wraps correctly.
    always_comb begin
        if (cur_addr_q == ADDR_W'(DEPTH - 1)) begin
            next_addr = '0;
        end else begin
            next_addr = cur_addr_q + ADDR_W'(1);
        end
    end

    always_comb begin
        cur_addr_d = cur_addr_q;
        beats_d    = beats_q;
        if (load) begin
            cur_addr_d = load_addr;
            beats_d    = {1'b0, load_len} + BEAT_W'(1);
        end else if (step) begin
            cur_addr_d = next_addr;
            beats_d    = beats_q - BEAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_addr_q <= '0;
            beats_q    <= '0;
        end else begin
            cur_addr_q <= cur_addr_d;
            beats_q    <= beats_d;
        end
    end

    assign cur_addr = cur_addr_q;
    assign last     = (beats_q == BEAT_W'(1));

endmodule

// File: rtl/ram_burst_master.sv
// ram_burst_master: single-command burst read/write master for a small RAM.
//   clk, reset                      clock, async active-high reset
//   cmd_valid/cmd_ready             command handshake (ready only when idle)
//   cmd_write, cmd_addr, cmd_len    direction, start address, beats minus one
//   wr_data/wr_valid/wr_ready       write beat stream
//   rd_data/rd_valid/rd_last/rd_ready  read beat stream
//   mem_we, mem_addr, mem_wdata, mem_rdata  RAM port (RAM writes on rising
//                                   edge, refreshes read data on falling edge)
//   busy                            controller not idle
//   done                            one-cycle burst-complete pulse
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// WRITE   | accepting write beats, wr_ready high
// RD_ADDR | read address presented, RAM data captured at end of cycle
// RD_RESP | read beat held on rd_* until rd_ready
module ram_burst_master #(
    parameter int DATA_W = ram_pkg::DATA_W,
    parameter int DEPTH  = ram_pkg::DEPTH,
    parameter int MEM_AW = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [ram_pkg::ADDR_W-1:0] cmd_addr,
    input  logic [ram_pkg::ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       rd_last,
    input  logic                       rd_ready,
    output logic                       mem_we,
    output logic [MEM_AW-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       busy,
    output logic                       done
);
    import ram_pkg::*;

    state_t state_q, state_d;

    logic              ag_load;
    logic              ag_step;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] next_addr;
    logic              last;

    logic              mem_we_q,    mem_we_d;
    logic [MEM_AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rd_data_q,   rd_data_d;
    logic              rd_valid_q,  rd_valid_d;
    logic              rd_last_q,   rd_last_d;
    logic              done_q,      done_d;

    ram_addr_gen #(
        .DEPTH (DEPTH)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (ag_load),
        .step      (ag_step),
        .load_addr (cmd_addr),
        .load_len  (cmd_len),
        .cur_addr  (cur_addr),
        .next_addr (next_addr),
        .last      (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = cmd_write ? WRITE : RD_ADDR;
                end
            end
            WRITE: begin
                if (wr_valid && last) begin
                    state_d = IDLE;
                end
            end
            RD_ADDR: begin
                state_d = RD_RESP;
            end
            RD_RESP: begin
                if (rd_ready) begin
                    state_d = last ? IDLE : RD_ADDR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs are computed one cycle ahead; mem_addr is set on the
    // edge that enters RD_ADDR so the RAM's falling-edge read lands within it.
    always_comb begin
        ag_load     = 1'b0;
        ag_step     = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q;
        rd_last_d   = rd_last_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    ag_load = 1'b1;
                    if (!cmd_write) begin
                        mem_addr_d = MEM_AW'(cmd_addr);
                    end
                end
            end
            WRITE: begin
                if (wr_valid) begin
                    ag_step     = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = MEM_AW'(cur_addr);
                    mem_wdata_d = wr_data;
                    done_d      = last;
                end
            end
            RD_ADDR: begin
                rd_data_d  = mem_rdata;
                rd_valid_d = 1'b1;
                rd_last_d  = last;
            end
            RD_RESP: begin
                if (rd_ready) begin
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                    if (last) begin
                        done_d = 1'b1;
                    end else begin
                        ag_step    = 1'b1;
                        mem_addr_d = MEM_AW'(next_addr);
                    end
                end
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign wr_ready  = (state_q == WRITE);
    assign busy      = (state_q != IDLE);

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ram_burst_master.sv
module tb_ram_burst_master;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [2:0] cmd_addr, cmd_len;
    logic [7:0] wr_data;
    logic       wr_valid, wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid, rd_last, rd_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy, done;

    always #5 clk = ~clk;

    ram_burst_master #(.DATA_W(8), .DEPTH(8), .MEM_AW(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done)
    );

    // RAM: writes on rising edge, read data refreshed on falling edge
    logic [7:0] mem [8];
    always @(posedge clk) if (mem_we) mem[mem_addr[2:0]] <= mem_wdata;
    always @(negedge clk) mem_rdata <= mem[mem_addr[2:0]];

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int exp_done = 0;
    logic [15:0] wq [$];
    logic [8:0]  rq [$];
    logic [7:0]  dat [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [8:0]  re;
        logic [15:0] we;
        if (rd_valid && rd_ready) begin
            if (rq.size() == 0) begin
                total++; bad++;
                $display("FAIL rd_unexpected: got beat %0h expected none", rd_data);
            end else begin
                re = rq.pop_front();
                chk("rd_data", {24'd0, rd_data}, {24'd0, re[7:0]});
                chk("rd_last", {31'd0, rd_last}, {31'd0, re[8]});
            end
        end
        if (mem_we) begin
            if (wq.size() == 0) begin
                total++; bad++;
                $display("FAIL mem_we_unexpected: got addr %0h data %0h expected none", mem_addr, mem_wdata);
            end else begin
                we = wq.pop_front();
                chk("mem_addr", {24'd0, mem_addr}, {24'd0, we[15:8]});
                chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, we[7:0]});
            end
        end
        if (done) done_cnt++;
    end

    task automatic wait_cmd();
        int n = 0;
        do begin @(negedge clk); n++; end while (!cmd_ready && n < 50);
        if (!cmd_ready) begin total++; bad++; $display("FAIL cmd_timeout: got cmd_ready 0 expected 1"); end
        @(posedge clk); #1;
    endtask

    task automatic finish_burst(input string name);
        int n = 0;
        while (busy && n < 100) begin @(negedge clk); n++; end
        if (busy) begin total++; bad++; $display("FAIL %s_idle_timeout: got busy 1 expected 0", name); end
        @(posedge clk); #1;
        chk({name, "_done_cnt"}, done_cnt, exp_done);
    endtask

    task automatic send_beat(input logic [7:0] d);
        int n = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        do begin @(negedge clk); n++; end while (!wr_ready && n < 50);
        if (!wr_ready) begin total++; bad++; $display("FAIL wr_timeout: got wr_ready 0 expected 1"); end
        chk("cmd_ready_in_write", {31'd0, cmd_ready}, 0);
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic write_burst(input int addr, input int len, input int gap, input bit hold);
        logic [2:0] a;
        cmd_valid = 1'b1; cmd_write = 1'b1;
        cmd_addr = 3'(addr); cmd_len = 3'(len);
        wait_cmd();
        if (!hold) cmd_valid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            a = 3'(addr + i);
            wq.push_back({5'd0, a, dat[i]});
            send_beat(dat[i]);
            if (i != len) begin
                repeat (gap) begin
                    @(posedge clk); #1;
                    chk("gap_mem_we", {31'd0, mem_we}, 0);
                    chk("gap_cmd_ready", {31'd0, cmd_ready}, 0);
                end
            end
        end
        cmd_valid = 1'b0;
        exp_done++;
        finish_burst("wr");
    endtask

    task automatic read_burst(input int addr, input int len, input int stall);
        int n;
        logic [2:0] a;
        cmd_valid = 1'b1; cmd_write = 1'b0;
        cmd_addr = 3'(addr); cmd_len = 3'(len);
        wait_cmd();
        cmd_valid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            a = 3'(addr + i);
            rq.push_back({(i == len), dat[i]});
            n = 0;
            do begin @(negedge clk); n++; end while (!rd_valid && n < 20);
            chk("rd_latency", n, 2);
            if (i == stall) begin
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_rd_valid", {31'd0, rd_valid}, 1);
                    chk("stall_rd_data", {24'd0, rd_data}, {24'd0, dat[i]});
                    chk("stall_rd_last", {31'd0, rd_last}, (i == len) ? 1 : 0);
                    chk("stall_mem_addr", {24'd0, mem_addr}, {29'd0, a});
                end
            end
            @(posedge clk); #1; rd_ready = 1'b1;
            @(posedge clk); #1; rd_ready = 1'b0;
        end
        exp_done++;
        finish_burst("rd");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("rst_mem_we", {31'd0, mem_we}, 0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 0);
        chk("rst_rd_data", {24'd0, rd_data}, 0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 0);
        chk("rst_rd_last", {31'd0, rd_last}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
        chk("rst_wr_ready", {31'd0, wr_ready}, 0);

        // command offered during reset is taken on the first edge after release
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd4; cmd_len = 3'd0;
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("first_accept_busy", {31'd0, busy}, 1);
        chk("first_accept_wr_ready", {31'd0, wr_ready}, 1);
        cmd_valid = 1'b0;
        wq.push_back({8'd4, 8'h80});
        send_beat(8'h80);
        exp_done++;
        finish_burst("t0_wr");

        // single read of addr4
        dat[0] = 8'h80;
        read_burst(4, 0, -1);

        // full 8-beat write then read from addr0
        dat[0] = 8'h94; dat[1] = 8'hF0; dat[2] = 8'hAA; dat[3] = 8'h83;
        dat[4] = 8'h80; dat[5] = 8'h01; dat[6] = 8'hB3; dat[7] = 8'hFF;
        write_burst(0, 7, 0, 1'b0);
        read_burst(0, 7, -1);

        // wrapping burst at addr6, with wr_valid gaps and cmd_valid held high
        dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33;
        write_burst(6, 2, 2, 1'b1);
        read_burst(6, 2, -1);

        // read stalled for 3 cycles on beat 2
        dat[3] = 8'hF0;
        read_burst(6, 3, 1);

        // reset after two beats of a 4-beat write at addr1
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd1; cmd_len = 3'd3;
        wait_cmd();
        cmd_valid = 1'b0;
        wq.push_back({8'd1, 8'h5A});
        wq.push_back({8'd2, 8'h6B});
        send_beat(8'h5A);
        send_beat(8'h6B);
        wr_valid = 1'b1; wr_data = 8'h7C;
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_mem_we", {31'd0, mem_we}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_mem_addr", {24'd0, mem_addr}, 0);
        wr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_ram1", {24'd0, mem[1]}, 32'h5A);
        chk("mid_rst_ram2", {24'd0, mem[2]}, 32'h6B);
        chk("mid_rst_ram3", {24'd0, mem[3]}, 32'h83);
        reset = 1'b0;
        dat[0] = 8'h5A; dat[1] = 8'h6B; dat[2] = 8'h83;
        read_burst(1, 2, -1);

        chk("rd_queue_empty", rq.size(), 0);
        chk("wr_queue_empty", wq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_burst_master.md
RAM_BURST_MASTER -- requirements
Module: ram_burst_master

Interface
REQ-001 SHALL have parameter DATA_W, default 8: memory word width.
REQ-002 SHALL have parameter DEPTH, default 8: words in the attached RAM; address wraps modulo DEPTH.
REQ-003 SHALL have parameter MEM_AW, default 8: width of the RAM address port.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, as the following port lines define.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port cmd_valid  input  1  command offered.
REQ-008 SHALL have port cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-009 SHALL have port cmd_write  input  1  1 = burst write, 0 = burst read.
REQ-010 SHALL have port cmd_addr  input  3  start word address.
REQ-011 SHALL have port cmd_len  input  3  beats minus one (1..8 beats).
REQ-012 SHALL have port wr_data  input  DATA_W  write beat data.
REQ-013 SHALL have port wr_valid  input  1  write beat offered.
REQ-014 SHALL have port wr_ready  output  1  write beat accepted.
REQ-015 SHALL have port rd_data  output  DATA_W  read beat data.
REQ-016 SHALL have port rd_valid  output  1  read beat available.
REQ-017 SHALL have port rd_last  output  1  final beat of the burst.
REQ-018 SHALL have port rd_ready  input  1  read beat consumed.
REQ-019 SHALL have ports mem_we (output, 1), mem_addr (output, MEM_AW), mem_wdata (output, DATA_W), mem_rdata (input, DATA_W): the RAM side. The RAM writes on the rising edge and updates its read data on the falling edge.
REQ-020 SHALL have ports busy (output, 1), not IDLE, and done (output, 1), a one-cycle burst-complete pulse.

Function
REQ-021 SHALL implement FSM states IDLE, WRITE, RD_ADDR and RD_RESP, each with registered outputs except cmd_ready and wr_ready.
REQ-022 SHALL assert cmd_ready only in IDLE; on cmd_valid it latches cur_addr=cmd_addr and beats=cmd_len+1, then enters WRITE (cmd_write=1) or RD_ADDR (cmd_write=0).
REQ-023 SHALL ignore cmd_valid outside IDLE; no queuing.
REQ-024 In WRITE, SHALL assert wr_ready=1; on each wr_valid&&wr_ready edge it registers mem_we=1, mem_addr=cur_addr, mem_wdata=wr_data, then increments cur_addr mod DEPTH and decrements beats.
REQ-025 SHALL hold mem_we=0 on any edge without an accepted write beat; wr_valid gaps stall the burst indefinitely.
REQ-026 After the last write beat, SHALL return to IDLE and pulse done=1 for exactly one cycle.
REQ-027 On entry to RD_ADDR, SHALL register mem_addr=cur_addr; at the end of RD_ADDR it captures mem_rdata into rd_data, sets rd_valid=1 and sets rd_last=(beats==1), then enters RD_RESP. Read latency: rd_valid high one cycle after the accepting edge.
REQ-028 In RD_RESP, SHALL hold rd_data, rd_valid and rd_last stable while rd_ready=0.
REQ-029 On rd_ready=1 in RD_RESP, SHALL clear rd_valid; if beats>1, it increments cur_addr mod DEPTH and returns to RD_ADDR; otherwise it goes to IDLE with done=1.
REQ-030 SHALL drive the upper MEM_AW-3 bits of mem_addr to zero, and SHALL wrap address 7 to 0 within a burst.
REQ-031 SHALL assert busy=1 in every state except IDLE.

Reset
REQ-032 On reset assertion, SHALL immediately force state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, rd_data=0, rd_valid=0, rd_last=0, done=0, cur_addr=0 and beats=0.
REQ-033 Reset mid-burst SHALL abandon the burst without issuing a further mem_we; words already written stay in the RAM.
REQ-034 The first command SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-035 Package ram_pkg SHALL hold DATA_W, DEPTH, ADDR_W=3 and the FSM state enum.
REQ-036 The address/beat counter SHALL be a single sub-module ram_addr_gen (load, increment mod DEPTH, beats==1 flag).

Verification
REQ-037 Write addr0 len7 with data 0x94,0xF0,0xAA,0x83,0x80,0x01,0xB3,0xFF, then read addr0 len7 -> the same eight values in order, rd_last only on 0xFF, done pulses once per burst.
REQ-038 Write addr6 len2 with 0x11,0x22,0x33 -> mem_addr 6,7,0; a read of addr6 len2 returns 0x11,0x22,0x33.
REQ-039 Read with rd_ready low for 3 cycles on beat 2 -> rd_data and rd_valid stay stable, no mem_addr change, and the burst completes after release.
REQ-040 Single read of addr4 after writing 0x80 -> rd_valid high one cycle after acceptance, rd_data=0x80, rd_last=1.
REQ-041 Assert reset after the 2nd beat of a 4-beat write -> mem_we=0 immediately, busy=0, and only 2 words are written.
REQ-042 cmd_valid held high during a burst -> no second acceptance until IDLE; wr_valid gaps -> mem_we=0 in those cycles.
